// File: rtl/vx_tensor_gpr_slave_pkg.sv
// Shared types and geometry for the tensor operand collector's GPR responder.
// Geometry sizes the register file; the request/response structs define the gpr_if payloads.
package vx_tensor_gpr_slave_pkg;

  localparam int ISSUE_WIS     = 4;
  localparam int SIMD_COUNT    = 2;
  localparam int NUM_REGS      = 32;
  localparam int SIMD_WIDTH    = 4;
  localparam int XLEN          = 32;
  localparam int SRC_OPD_WIDTH = 2;

  localparam int ISSUE_WIS_W = (ISSUE_WIS > 1) ? $clog2(ISSUE_WIS) : 1;
  localparam int SIMD_IDX_W  = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
  localparam int NR_BITS     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam int GPR_DEPTH  = ISSUE_WIS * SIMD_COUNT * NUM_REGS;
  localparam int GPR_ADDR_W = (GPR_DEPTH > 1) ? $clog2(GPR_DEPTH) : 1;
  localparam int GPR_WORD_W = SIMD_WIDTH * XLEN;

  typedef logic [SIMD_WIDTH-1:0][XLEN-1:0] gpr_word_t;

  typedef struct packed {
    logic [SRC_OPD_WIDTH-1:0] opd_id;
    logic [SIMD_IDX_W-1:0]    sid;
    logic [ISSUE_WIS_W-1:0]   wis;
    logic [NR_BITS-1:0]       reg_id;
  } gpr_req_data_t;

  typedef struct packed {
    logic [SRC_OPD_WIDTH-1:0] opd_id;
    gpr_word_t                data;
  } gpr_rsp_data_t;

  localparam int GPR_REQ_W = $bits(gpr_req_data_t);
  localparam int GPR_RSP_W = $bits(gpr_rsp_data_t);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } gpr_state_e;

  // Storage is laid out as {wis, sid, reg}.
  function automatic logic [GPR_ADDR_W-1:0] gpr_addr(
    input logic [ISSUE_WIS_W-1:0] wis,
    input logic [SIMD_IDX_W-1:0]  sid,
    input logic [NR_BITS-1:0]     reg_id
  );
    return {wis, sid, reg_id};
  endfunction

endpackage

// File: rtl/vx_tensor_gpr_slave_dp_ram.sv
// Simple dual-port register-file RAM: one lane-masked write port, one registered read port.
// A read and write to the same address in one cycle return the old contents.
module vx_tensor_gpr_slave_dp_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [LANES-1:0]          wmask,
  input  logic [LANES*LANE_W-1:0]   wdata,
  input  logic                      re,
  input  logic [ADDR_W-1:0]         raddr,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem_q [DEPTH];
  logic [LANES*LANE_W-1:0] rdata_q;
  logic [LANES*LANE_W-1:0] rdata_d;

  // Read data only moves when a read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem_q[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vx_tensor_gpr_slave.sv
// GPR responder behind the tensor operand collector: zero-sweep after reset, lane-masked
// writebacks, and one operand vector per accepted request with write-first forwarding.
module vx_tensor_gpr_slave
  import vx_tensor_gpr_slave_pkg::*;
#(
  parameter string INSTANCE_ID = "",
  parameter int    OUT_REG     = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [GPR_REQ_W-1:0]     req_data,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [GPR_RSP_W-1:0]     rsp_data,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ISSUE_WIS_W-1:0]   wb_wis,
  input  logic [SIMD_IDX_W-1:0]    wb_sid,
  input  logic [NR_BITS-1:0]       wb_rd,
  input  logic [SIMD_WIDTH-1:0]    wb_tmask,
  input  logic [GPR_WORD_W-1:0]    wb_data
);

  localparam logic unused_has_id = (INSTANCE_ID != "");
  localparam logic [GPR_ADDR_W-1:0] LAST_ADDR = GPR_ADDR_W'(GPR_DEPTH - 1);

  gpr_req_data_t   req_s;
  gpr_state_e      state_q, state_d;
  logic [GPR_ADDR_W-1:0] cnt_q, cnt_d;

  logic                  req_fire_s, wb_fire_s, wb_hit_s;
  logic [GPR_ADDR_W-1:0] raddr_s, waddr_s;
  logic                  ram_we_s;
  logic [GPR_ADDR_W-1:0] ram_waddr_s;
  logic [SIMD_WIDTH-1:0] ram_wmask_s;
  gpr_word_t             ram_wdata_s, ram_rdata_s;

  logic                     s1_valid_q, s1_valid_d;
  logic [SRC_OPD_WIDTH-1:0] s1_opd_q, s1_opd_d;
  logic                     s1_zero_q, s1_zero_d;
  logic [SIMD_WIDTH-1:0]    s1_fwd_mask_q, s1_fwd_mask_d;
  gpr_word_t                s1_fwd_data_q, s1_fwd_data_d;

  logic          rsp1_valid_s;
  gpr_rsp_data_t rsp1_data_s;

  assign req_s      = req_data;
  assign req_ready  = (state_q == ST_READY);
  assign wb_ready   = (state_q == ST_READY);
  assign req_fire_s = req_valid && (state_q == ST_READY);
  assign wb_fire_s  = wb_valid && (state_q == ST_READY);
  assign raddr_s    = gpr_addr(req_s.wis, req_s.sid, req_s.reg_id);
  assign waddr_s    = gpr_addr(wb_wis, wb_sid, wb_rd);
  assign wb_hit_s   = wb_fire_s && (wb_rd != {NR_BITS{1'b0}}) && (waddr_s == raddr_s);

  // Init sweep walks every address once, then parks in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = cnt_q;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + GPR_ADDR_W'(1);
        end
      end
      ST_READY: begin
        state_d = ST_READY;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {GPR_ADDR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= {GPR_ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM write port is owned by the sweep during INIT, by writebacks afterwards (x0 dropped).
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = waddr_s;
    ram_wmask_s = wb_tmask;
    ram_wdata_s = wb_data;
    if (state_q == ST_INIT) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = cnt_q;
      ram_wmask_s = {SIMD_WIDTH{1'b1}};
      ram_wdata_s = {GPR_WORD_W{1'b0}};
    end else begin
      ram_we_s    = wb_fire_s && (wb_rd != {NR_BITS{1'b0}});
    end
  end

  vx_tensor_gpr_slave_dp_ram #(
    .DEPTH  (GPR_DEPTH),
    .ADDR_W (GPR_ADDR_W),
    .LANES  (SIMD_WIDTH),
    .LANE_W (XLEN)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wmask (ram_wmask_s),
    .wdata (ram_wdata_s),
    .re    (req_fire_s),
    .raddr (raddr_s),
    .rdata (ram_rdata_s)
  );

  // Capture the side info for the read: operand id, x0 flag and same-cycle write lanes.
  always_comb begin
    s1_valid_d    = req_fire_s;
    s1_opd_d      = s1_opd_q;
    s1_zero_d     = s1_zero_q;
    s1_fwd_mask_d = s1_fwd_mask_q;
    s1_fwd_data_d = s1_fwd_data_q;
    if (req_fire_s) begin
      s1_opd_d      = req_s.opd_id;
      s1_zero_d     = (req_s.reg_id == {NR_BITS{1'b0}});
      s1_fwd_mask_d = wb_hit_s ? wb_tmask : {SIMD_WIDTH{1'b0}};
      s1_fwd_data_d = wb_data;
    end else begin
      s1_opd_d      = s1_opd_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_opd_q      <= {SRC_OPD_WIDTH{1'b0}};
      s1_zero_q     <= 1'b0;
      s1_fwd_mask_q <= {SIMD_WIDTH{1'b0}};
      s1_fwd_data_q <= {GPR_WORD_W{1'b0}};
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_opd_q      <= s1_opd_d;
      s1_zero_q     <= s1_zero_d;
      s1_fwd_mask_q <= s1_fwd_mask_d;
      s1_fwd_data_q <= s1_fwd_data_d;
    end
  end

  // Per-lane merge of RAM data, forwarded write data and the x0 mask.
  always_comb begin
    rsp1_valid_s       = s1_valid_q;
    rsp1_data_s.opd_id = s1_opd_q;
    rsp1_data_s.data   = ram_rdata_s;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (s1_zero_q) begin
        rsp1_data_s.data[i] = {XLEN{1'b0}};
      end else if (s1_fwd_mask_q[i]) begin
        rsp1_data_s.data[i] = s1_fwd_data_q[i];
      end else begin
        rsp1_data_s.data[i] = ram_rdata_s[i];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                 out_valid_q, out_valid_d;
    logic [GPR_RSP_W-1:0] out_data_q, out_data_d;

    assign out_valid_d = rsp1_valid_s;
    assign out_data_d  = rsp1_data_s;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid_q <= 1'b0;
        out_data_q  <= {GPR_RSP_W{1'b0}};
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign rsp_valid = out_valid_q;
    assign rsp_data  = out_data_q;
  end else begin : g_no_out_reg
    assign rsp_valid = rsp1_valid_s;
    assign rsp_data  = rsp1_data_s;
  end

endmodule

// File: tb/tb_vx_tensor_gpr_slave.sv
// Randomized bench for vx_tensor_gpr_slave with an array-based register-file model;
// drives an OUT_REG=0 and an OUT_REG=1 instance in lockstep.
module tb_vx_tensor_gpr_slave;
  import vx_tensor_gpr_slave_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   req_valid = 1'b0;
  logic [GPR_REQ_W-1:0]   req_data = '0;
  logic                   wb_valid = 1'b0;
  logic [ISSUE_WIS_W-1:0] wb_wis = '0;
  logic [SIMD_IDX_W-1:0]  wb_sid = '0;
  logic [NR_BITS-1:0]     wb_rd = '0;
  logic [SIMD_WIDTH-1:0]  wb_tmask = '0;
  logic [GPR_WORD_W-1:0]  wb_data = '0;

  logic                 req_ready, wb_ready, rsp_valid;
  logic [GPR_RSP_W-1:0] rsp_data;
  logic                 req_ready2, wb_ready2, rsp_valid2;
  logic [GPR_RSP_W-1:0] rsp_data2;

  always #5 clk = ~clk;

  vx_tensor_gpr_slave #(.INSTANCE_ID("g0"), .OUT_REG(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wis(wb_wis), .wb_sid(wb_sid), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data));

  vx_tensor_gpr_slave #(.INSTANCE_ID("g1"), .OUT_REG(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .wb_valid(wb_valid), .wb_ready(wb_ready2),
    .wb_wis(wb_wis), .wb_sid(wb_sid), .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data));

  int checks = 0;
  int failures = 0;

  logic [GPR_WORD_W-1:0] model_mem [GPR_DEPTH];
  logic                  exp1_v = 1'b0, exp2_v = 1'b0;
  logic [GPR_RSP_W-1:0]  exp1_d = '0, exp2_d = '0;

  function automatic int maddr(input int wis, input int sid, input int rg);
    return (wis * SIMD_COUNT + sid) * NUM_REGS + rg;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < GPR_DEPTH; i++) model_mem[i] = '0;
    exp1_v = 1'b0; exp2_v = 1'b0; exp1_d = '0; exp2_d = '0;
  endtask

  task automatic drive_read(input int opd, input int wis, input int sid, input int rg);
    gpr_req_data_t r;
    r.opd_id = opd[SRC_OPD_WIDTH-1:0];
    r.sid    = sid[SIMD_IDX_W-1:0];
    r.wis    = wis[ISSUE_WIS_W-1:0];
    r.reg_id = rg[NR_BITS-1:0];
    req_valid = 1'b1;
    req_data  = r;
  endtask

  task automatic drive_write(input int wis, input int sid, input int rd,
                             input logic [SIMD_WIDTH-1:0] tm, input logic [GPR_WORD_W-1:0] d);
    wb_valid = 1'b1;
    wb_wis   = wis[ISSUE_WIS_W-1:0];
    wb_sid   = sid[SIMD_IDX_W-1:0];
    wb_rd    = rd[NR_BITS-1:0];
    wb_tmask = tm;
    wb_data  = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  // One clock: compute what the current request must return, apply the write to the model.
  task automatic tick();
    gpr_req_data_t r;
    logic [GPR_WORD_W-1:0] e;
    int ra, wa;
    r  = req_data;
    ra = maddr(int'(r.wis), int'(r.sid), int'(r.reg_id));
    wa = maddr(int'(wb_wis), int'(wb_sid), int'(wb_rd));
    e  = model_mem[ra];
    for (int i = 0; i < SIMD_WIDTH; i++)
      if (wb_valid && wb_rd != 0 && wa == ra && wb_tmask[i]) e[i*XLEN +: XLEN] = wb_data[i*XLEN +: XLEN];
    if (r.reg_id == 0) e = '0;
    if (wb_valid && wb_rd != 0)
      for (int i = 0; i < SIMD_WIDTH; i++)
        if (wb_tmask[i]) model_mem[wa][i*XLEN +: XLEN] = wb_data[i*XLEN +: XLEN];
    @(posedge clk); #1;
    exp2_v = exp1_v; exp2_d = exp1_d;
    exp1_v = req_valid; exp1_d = {r.opd_id, e};
  endtask

  task automatic test_reset();
    int n;
    #1;
    checks++;
    if (req_ready !== 1'b0 || wb_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got req_ready=%b wb_ready=%b rsp_valid=%b rsp_valid2=%b, want all 0",
               req_ready, wb_ready, rsp_valid, rsp_valid2);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    n = 0;
    while (req_ready !== 1'b1 && n < 2 * GPR_DEPTH) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != GPR_DEPTH || wb_ready !== 1'b1 || req_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL init_sweep: got %0d cycles (wb_ready=%b req_ready2=%b), want %0d cycles",
               n, wb_ready, req_ready2, GPR_DEPTH);
    end
    drive_read(1, 0, 0, 5);
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      checks++;
      if (rsp_valid !== exp1_v || (exp1_v && rsp_data !== exp1_d)) begin
        failures++; $display("FAIL idle_read c%0d: got v=%b %h, want v=%b %h", c, rsp_valid, rsp_data, exp1_v, exp1_d);
      end
      checks++;
      if (rsp_valid2 !== exp2_v || (exp2_v && rsp_data2 !== exp2_d)) begin
        failures++; $display("FAIL idle_read_outreg c%0d: got v=%b %h, want v=%b %h", c, rsp_valid2, rsp_data2, exp2_v, exp2_d);
      end
    end
  endtask

  task automatic test_write_read();
    logic [GPR_WORD_W-1:0] want;
    // full mask, partial mask, then same-cycle forwarding on wis1/sid0/r7
    drive_write(1, 0, 7, 4'hF, {32'h103, 32'h102, 32'h101, 32'h100});
    tick(); idle();
    drive_read(2, 1, 0, 7);
    tick(); idle();
    want = {32'h103, 32'h102, 32'h101, 32'h100};
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== {2'd2, want} || rsp_data !== exp1_d) begin
      failures++; $display("FAIL full_mask: got v=%b %h, want v=1 %h", rsp_valid, rsp_data, {2'd2, want});
    end
    drive_write(1, 0, 7, 4'b0101, {4{32'hAA}});
    tick(); idle();
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_data2 !== {2'd2, want}) begin
      failures++; $display("FAIL full_mask_outreg: got v=%b %h, want v=1 %h", rsp_valid2, rsp_data2, {2'd2, want});
    end
    drive_read(3, 1, 0, 7);
    tick(); idle();
    want = {32'h103, 32'hAA, 32'h101, 32'hAA};
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== {2'd3, want} || rsp_data !== exp1_d) begin
      failures++; $display("FAIL partial_mask: got v=%b %h, want v=1 %h", rsp_valid, rsp_data, {2'd3, want});
    end
    drive_read(1, 1, 0, 7);
    drive_write(1, 0, 7, 4'b0011, {4{32'h55}});
    tick(); idle();
    want = {32'h103, 32'hAA, 32'h55, 32'h55};
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== {2'd1, want} || rsp_data !== exp1_d) begin
      failures++; $display("FAIL forward: got v=%b %h, want v=1 %h", rsp_valid, rsp_data, {2'd1, want});
    end
    drive_read(0, 1, 0, 7);
    drive_write(1, 0, 7, 4'b1111, {4{32'h77}});
    tick();
    idle();
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_data2 !== {2'd1, want}) begin
      failures++; $display("FAIL forward_outreg: got v=%b %h, want v=1 %h", rsp_valid2, rsp_data2, {2'd1, want});
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp1_d) begin
      failures++; $display("FAIL forward_all_lanes: got v=%b %h, want v=1 %h", rsp_valid, rsp_data, exp1_d);
    end
    tick();
  endtask

  task automatic test_x0();
    drive_write(2, 1, 0, 4'hF, {4{32'hFF}});
    tick(); idle();
    drive_read(2, 2, 1, 0);
    tick(); idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== {2'd2, {GPR_WORD_W{1'b0}}}) begin
      failures++; $display("FAIL x0_read: got v=%b %h, want v=1 zeros", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive_read(k % 3, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 7));
      else req_valid = 1'b0;
      if (k % 2 == 0) drive_write($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(1, 7),
                                  4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else wb_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== exp1_v || (exp1_v && rsp_data !== exp1_d) || (k < 8 && rsp_data[GPR_RSP_W-1 -: 2] !== 2'(k % 3))) begin
        failures++; $display("FAIL b2b k%0d: got v=%b %h, want v=%b %h", k, rsp_valid, rsp_data, exp1_v, exp1_d);
      end
      checks++;
      if (rsp_valid2 !== exp2_v || (exp2_v && rsp_data2 !== exp2_d)) begin
        failures++; $display("FAIL b2b_outreg k%0d: got v=%b %h, want v=%b %h", k, rsp_valid2, rsp_data2, exp2_v, exp2_d);
      end
    end
    idle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) drive_read($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
      else req_valid = 1'b0;
      if ($urandom_range(0, 1) != 0) drive_write($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                                                 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else wb_valid = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== exp1_v || (exp1_v && rsp_data !== exp1_d)) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL random k%0d: got v=%b %h, want v=%b %h", k, rsp_valid, rsp_data, exp1_v, exp1_d);
      end
      checks++;
      if (rsp_valid2 !== exp2_v || (exp2_v && rsp_data2 !== exp2_d)) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL random_outreg k%0d: got v=%b %h, want v=%b %h", k, rsp_valid2, rsp_data2, exp2_v, exp2_d);
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    int n;
    int stale = 0;
    drive_write(1, 0, 9, 4'hF, {4{32'hDEAD}});
    tick();
    drive_read(1, 1, 0, 9);
    tick();
    drive_read(2, 1, 0, 9);
    tick(); idle();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_valid2 !== 1'b0) begin
      failures++; $display("FAIL reset_async_clear: got rsp_valid=%b rsp_valid2=%b, want 0 0", rsp_valid, rsp_valid2);
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || rsp_valid2 !== 1'b0 || req_ready !== 1'b0) stale++;
    end
    reset = 1'b0;
    model_clear();
    n = 0;
    while (req_ready !== 1'b1 && n < 2 * GPR_DEPTH) begin
      if (rsp_valid !== 1'b0 || rsp_valid2 !== 1'b0) stale++;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (stale != 0 || n != GPR_DEPTH) begin
      failures++; $display("FAIL reset_midstream: got %0d stale cycles, sweep %0d, want 0 stale, sweep %0d", stale, n, GPR_DEPTH);
    end
    drive_read(3, 1, 0, 9);
    tick(); idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== {2'd3, {GPR_WORD_W{1'b0}}} || rsp_data !== exp1_d) begin
      failures++; $display("FAIL reset_cleared_data: got v=%b %h, want v=1 zeros", rsp_valid, rsp_data);
    end
    tick();
    checks++;
    if (rsp_valid2 !== 1'b1 || rsp_data2 !== {2'd3, {GPR_WORD_W{1'b0}}}) begin
      failures++; $display("FAIL reset_cleared_outreg: got v=%b %h, want v=1 zeros", rsp_valid2, rsp_data2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_tensor_gpr_slave.md
# VX_tensor_gpr_slave

Register-file responder for the tensor operand collector's GPR request channel. It sits behind the collector's `gpr_if` master port. It holds per-warp-slot, per-SIMD-slice architectural registers and returns a full `SIMD_WIDTH`-lane operand vector for each accepted request. It also absorbs lane-masked writebacks from the commit path and clears all storage in a sweep after reset.

## Interface

**Parameters**
- `INSTANCE_ID`, "": trace label.
- `OUT_REG`, 0: 1 adds a response output register, so latency goes from 1 to 2.

**Ports**
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `gpr_if`  slave  `VX_gpr_if`
  - `req_valid`, `req_ready`
  - `req_data` = {`opd_id`[SRC_OPD_WIDTH], `sid`[SIMD_IDX_W], `wis`[ISSUE_WIS_W], `reg_id`[NR_BITS]}
  - `rsp_valid`
  - `rsp_data` = {`opd_id`, `data`[SIMD_WIDTH][XLEN]}
  - The response channel has no ready; the initiator always accepts.
- `wb_valid`  in  1  writeback request.
- `wb_ready`  out  1  writeback accepted.
- `wb_wis`  in  ISSUE_WIS_W  writeback warp slot.
- `wb_sid`  in  SIMD_IDX_W  writeback SIMD slice.
- `wb_rd`  in  NR_BITS  destination register.
- `wb_tmask`  in  SIMD_WIDTH  lane write enables.
- `wb_data`  in  SIMD_WIDTH×XLEN  write data.

## Operation

**Storage**
- Depth `ISSUE_WIS*SIMD_COUNT*NUM_REGS`.
- Address = {wis, sid, reg}.
- Word = `SIMD_WIDTH*XLEN`, with per-lane write enable.
- One read port and one write port per cycle.

**State machine**
- `INIT`: entered on reset.
  - An address counter runs from 0 to depth-1, writing all-zero words with all lanes enabled.
  - `req_ready=0` and `wb_ready=0`.
  - Leaves for `READY` on the cycle after the counter writes depth-1.
- `READY`: `req_ready=1` and `wb_ready=1` every cycle. No other states.

**Reads**
- A request fires when `req_valid && req_ready`.
- Reading `reg_id==0` returns all zeros regardless of storage contents.
- `opd_id` travels alongside the read data unchanged.

**Writes**
- A write fires when `wb_valid && wb_ready`.
- Only lanes with `wb_tmask[i]=1` are updated.
- Writes to `rd==0` are dropped.

**Same-cycle read/write, same address (write-first)**
- Response lanes with the write enable set return `wb_data`.
- Other lanes return the stored values.
- A write in any later cycle does not affect an already-accepted read.

**Back-to-back traffic**
- One request per cycle is sustained in `READY`, with no bubbles.
- Reads and writes to different addresses are independent.

## Timing

**Reset values**
- `rsp_valid=0`, `req_ready=0`, `wb_ready=0`.
- State = `INIT`, counter = 0.
- `rsp_data` is don't-care while `rsp_valid=0`.

**Init sweep**
- `req_ready` first rises exactly `depth` cycles after `reset` deasserts.

**Read latency**
- Request fires in cycle N → `rsp_valid=1` in cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
- `rsp_valid` is asserted for exactly one cycle per request.

**Write visibility**
- A write fires in cycle N; any read that fires in cycle N+1 or later observes it.
- A read firing in cycle N sees it only through the write-first rule above.

**Reset mid-operation**
- Asynchronously clears the in-flight response pipeline, so no stale `rsp_valid` appears.
- Restarts the sweep from address 0.

**Counter width**
- `clog2(depth)` bits; no wrap-around past depth-1.

## Structure

**Shared package (`VX_gpu_pkg`)**
- `gpr_req_data_t`, `gpr_rsp_data_t`.
- Depth and address-width localparams derived from `ISSUE_WIS`, `SIMD_COUNT`, `NUM_REGS`.

**Sub-module**
- The storage is one sub-module: `VX_dp_ram` with per-lane write enable and registered read.
- Write-first forwarding, the x0 mask and the init sweep are done in this block around the RAM.

**Traces**
- Traces under `DBG_TRACE_PIPELINE` print every request, response and write.

## Test plan

- **Reset then idle**
  - Count cycles until `req_ready=1`; it equals depth.
  - Read wis=0, sid=0, reg=5 → data all zeros, `rsp_valid` high for one cycle at N+1.
- **Full-mask write then read**
  - Write wis=1, sid=0, rd=7, tmask=all ones, lane i = 0x100+i.
  - Next cycle read reg 7 with opd_id=2 → rsp opd_id=2, lane i = 0x100+i.
- **Partial mask**
  - Overwrite rd=7 with tmask=0b0101, data 0xAA.
  - Read → lanes 0 and 2 = 0xAA, lanes 1 and 3 keep 0x101 and 0x103.
- **Same-cycle forwarding**
  - Read and write the same address in one cycle, tmask=0b0011, data 0x55.
  - Response lanes 0–1 = 0x55, lanes 2–3 = prior contents.
- **x0 and throughput**
  - Write rd=0 with 0xFF, then read reg 0 → zeros.
  - Issue 8 back-to-back reads (opd_id 0,1,2,0,…) → 8 consecutive `rsp_valid` cycles with matching `opd_id` order.
- **Reset mid-stream**
  - Assert `reset` with 2 reads in flight → no `rsp_valid` after reset.
  - Sweep restarts; prior data reads back as zero.
